// File: rtl/key_schedule.sv
// DES key schedule: PC-1 on load, one rotate+PC-2 round key per clock into a 16-entry bank.
// Latency: 17 cycles accept-to-done, 1-cycle registered bank read; keys offered during RUN are dropped.
module key_schedule (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_dv,
  input  logic [63:0] i_key,
  output logic        o_key_ready,
  output logic        o_busy,
  output logic        o_sched_done,
  output logic        o_keys_valid,
  input  logic [3:0]  i_rd_round,
  input  logic        i_decrypt,
  output logic [47:0] o_rd_key
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Tables hold FIPS 1-based bit numbers, MSB-first
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] permute_pc1(input logic [63:0] key);
    logic [55:0] cd;
    logic [5:0]  src;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      src = 6'(64 - PC1[i]);
      cd  = {cd[54:0], key[src]};
    end
    return cd;
  endfunction

  function automatic logic [47:0] permute_pc2(input logic [55:0] cd);
    logic [47:0] k;
    logic [5:0]  src;
    k = '0;
    for (int i = 0; i < 48; i++) begin
      src = 6'(56 - PC2[i]);
      k   = {k[46:0], cd[src]};
    end
    return k;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  rnd_q;
  logic [27:0] c_q, d_q;
  logic [27:0] c_rot, d_rot;
  logic        rot_one;
  logic [47:0] round_key;
  logic [3:0]  wr_idx;
  logic [3:0]  rd_idx;
  logic        accept;
  logic        step;
  logic        keys_valid_q;
  logic [47:0] rd_key_q;
  logic [47:0] bank [16];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    step         = 1'b0;
    o_key_ready  = 1'b0;
    o_busy       = 1'b0;
    o_sched_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_key_ready = 1'b1;
        if (i_key_dv) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        step   = 1'b1;
        if (rnd_q == 5'd16) state_d = DONE;
      end
      DONE: begin
        o_key_ready  = 1'b1;
        o_sched_done = 1'b1;
        if (i_key_dv) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rounds 1, 2, 9 and 16 shift by one; the rest by two (28 in total)
  assign rot_one   = (rnd_q == 5'd1) || (rnd_q == 5'd2) || (rnd_q == 5'd9) || (rnd_q == 5'd16);
  assign c_rot     = rot_one ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
  assign d_rot     = rot_one ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
  assign round_key = permute_pc2({c_rot, d_rot});
  assign wr_idx    = rnd_q[3:0] - 4'd1;
  assign rd_idx    = i_decrypt ? ~i_rd_round : i_rd_round;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rnd_q        <= '0;
      c_q          <= '0;
      d_q          <= '0;
      keys_valid_q <= 1'b0;
      rd_key_q     <= '0;
    end else begin
      rd_key_q <= bank[rd_idx];
      if (accept) begin
        {c_q, d_q}   <= permute_pc1(i_key);
        rnd_q        <= 5'd1;
        keys_valid_q <= 1'b0;
      end else if (step) begin
        c_q   <= c_rot;
        d_q   <= d_rot;
        rnd_q <= (rnd_q == 5'd16) ? 5'd0 : rnd_q + 5'd1;
      end else if (state_q == DONE) begin
        keys_valid_q <= 1'b1;
      end
    end
  end

  // Contents are qualified by o_keys_valid, so the bank needs no reset
  always_ff @(posedge i_clk) begin
    if (step) bank[wr_idx] <= round_key;
  end

  assign o_keys_valid = keys_valid_q;
  assign o_rd_key     = rd_key_q;

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: scoreboarded bank reads against an independent DES key-schedule model.
module tb_key_schedule;

  logic        i_clk;
  logic        i_rst;
  logic        i_key_dv;
  logic [63:0] i_key;
  logic        o_key_ready;
  logic        o_busy;
  logic        o_sched_done;
  logic        o_keys_valid;
  logic [3:0]  i_rd_round;
  logic        i_decrypt;
  logic [47:0] o_rd_key;

  key_schedule dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_key_dv     (i_key_dv),
    .i_key        (i_key),
    .o_key_ready  (o_key_ready),
    .o_busy       (o_busy),
    .o_sched_done (o_sched_done),
    .o_keys_valid (o_keys_valid),
    .i_rd_round   (i_rd_round),
    .i_decrypt    (i_decrypt),
    .o_rd_key     (o_rd_key)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // Cumulative left rotation of C/D after each round
  int cum_t [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};

  logic [47:0] mk [16];
  logic [47:0] exp_q [$];
  int          cyc;
  logic        seen;
  logic [63:0] key_a, key_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic build_model(input logic [63:0] key);
    bit c0 [28];
    bit d0 [28];
    bit cd [56];
    logic [47:0] k;
    for (int i = 0; i < 28; i++) begin
      c0[i] = key[64 - pc1_t[i]];
      d0[i] = key[64 - pc1_t[i + 28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < 28; j++) begin
        cd[j]      = c0[(j + cum_t[r]) % 28];
        cd[j + 28] = d0[(j + cum_t[r]) % 28];
      end
      k = '0;
      for (int i = 0; i < 48; i++) k = {k[46:0], cd[pc2_t[i] - 1]};
      mk[r] = k;
    end
  endtask

  task automatic rd(input int idx, input logic dec, input logic [47:0] exp);
    i_rd_round = 4'(idx);
    i_decrypt  = dec;
    exp_q.push_back(exp);
    @(posedge i_clk); #1;
    chk("rd_key", {16'h0, o_rd_key}, {16'h0, exp_q.pop_front()});
  endtask

  // Back-to-back reads over all indices, both orders interleaved
  task automatic read_all();
    int idx;
    logic dec;
    for (int i = 0; i < 32; i++) begin
      idx = i >> 1;
      dec = 1'(i & 1);
      rd(idx, dec, dec ? mk[15 - idx] : mk[idx]);
    end
  endtask

  task automatic start_key(input logic [63:0] key);
    for (int n = 0; n < 40 && !o_key_ready; n++) begin
      @(posedge i_clk); #1;
    end
    chk("ready_before_load", 64'(o_key_ready), 64'd1);
    i_key_dv = 1'b1;
    i_key    = key;
    @(posedge i_clk); #1;
    i_key_dv = 1'b0;
    chk("busy_after_accept", 64'(o_busy), 64'd1);
    chk("valid_low_after_accept", 64'(o_keys_valid), 64'd0);
  endtask

  // Ends in the DONE cycle; cnt counts from the cycle the key was presented
  task automatic wait_done(input int poke, output int cnt);
    cnt = 1;
    for (int n = 0; n < 40; n++) begin
      if (cnt == poke) begin
        i_key_dv = 1'b1;
        i_key    = 64'h0;
      end
      @(posedge i_clk); #1;
      i_key_dv = 1'b0;
      cnt++;
      if (o_sched_done) break;
      chk("run_busy", 64'(o_busy), 64'd1);
      chk("run_ready", 64'(o_key_ready), 64'd0);
      chk("run_valid", 64'(o_keys_valid), 64'd0);
    end
    chk("sched_done_seen", 64'(o_sched_done), 64'd1);
    chk("done_cycle_valid", 64'(o_keys_valid), 64'd0);
  endtask

  task automatic finish_idle();
    @(posedge i_clk); #1;
    chk("idle_valid", 64'(o_keys_valid), 64'd1);
    chk("idle_done_pulse", 64'(o_sched_done), 64'd0);
    chk("idle_ready", 64'(o_key_ready), 64'd1);
    chk("idle_busy", 64'(o_busy), 64'd0);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_key_dv   = 1'b0;
    i_key      = '0;
    i_rd_round = '0;
    i_decrypt  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", 64'(o_key_ready), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_sched_done), 64'd0);
    chk("rst_valid", 64'(o_keys_valid), 64'd0);
    chk("rst_rd_key", {16'h0, o_rd_key}, 64'h0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // FIPS worked example
    start_key(64'h133457799BBCDFF1);
    wait_done(0, cyc);
    chk("done_latency", 64'(cyc), 64'd17);
    finish_idle();
    rd(0, 1'b0, 48'h1B02EFFC7072);
    rd(15, 1'b0, 48'hCB3D8B0E17F5);
    rd(0, 1'b1, 48'hCB3D8B0E17F5);
    build_model(64'h133457799BBCDFF1);
    read_all();

    // Parity bits must not reach any round key
    start_key(64'h0101010101010101);
    wait_done(0, cyc);
    finish_idle();
    for (int j = 0; j < 16; j++) mk[j] = 48'h0;
    read_all();
    start_key(64'hFFFFFFFFFFFFFFFF);
    wait_done(0, cyc);
    finish_idle();
    for (int j = 0; j < 16; j++) mk[j] = 48'hFFFFFFFFFFFF;
    read_all();

    // A key offered mid-RUN is dropped
    start_key(64'h133457799BBCDFF1);
    wait_done(5, cyc);
    chk("busy_reject_latency", 64'(cyc), 64'd17);
    finish_idle();
    rd(0, 1'b0, 48'h1B02EFFC7072);

    // Reset mid-RUN aborts without a done pulse
    start_key(64'hA5A5_5A5A_0F0F_F0F0);
    repeat (7) begin
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("abort_ready", 64'(o_key_ready), 64'd1);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_done", 64'(o_sched_done), 64'd0);
    chk("abort_valid", 64'(o_keys_valid), 64'd0);
    chk("abort_rd_key", {16'h0, o_rd_key}, 64'h0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge i_clk); #1;
      seen = seen | o_sched_done;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    start_key(64'h0);
    wait_done(0, cyc);
    finish_idle();
    build_model(64'h0);
    read_all();

    // Back-to-back: new key accepted in the DONE cycle
    key_a = {$urandom, $urandom};
    key_b = {$urandom, $urandom};
    start_key(key_a);
    wait_done(0, cyc);
    i_key_dv = 1'b1;
    i_key    = key_b;
    @(posedge i_clk); #1;
    i_key_dv = 1'b0;
    chk("b2b_busy", 64'(o_busy), 64'd1);
    chk("b2b_ready", 64'(o_key_ready), 64'd0);
    chk("b2b_valid", 64'(o_keys_valid), 64'd0);
    chk("b2b_done", 64'(o_sched_done), 64'd0);
    wait_done(0, cyc);
    chk("b2b_latency", 64'(cyc), 64'd17);
    finish_idle();
    build_model(key_b);
    read_all();

    // Random keys
    for (int t = 0; t < 200; t++) begin
      key_a = {$urandom, $urandom};
      start_key(key_a);
      wait_done(0, cyc);
      finish_idle();
      build_model(key_a);
      read_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
